// File: rtl/epoch_counter.sv
// ---------------------------------------------------------------------------
// epoch_counter
//
// Divides the 1 ms code-epoch strobe into navigation-bit and subframe
// boundaries. An epoch-within-bit counter and a bit-within-subframe counter
// free-run on every epoch strobe. Bit-sync logic aligns them with a load.
// Bit and subframe strobes reach the data demodulator only while synced.
// A watchdog drops sync if the epoch strobe goes quiet for too long.
//
// Ports:
//   clk              system clock
//   reset            asynchronous, active-low reset
//   epoch_in         single-cycle code-epoch strobe
//   load             single-cycle alignment request
//   load_epoch       epoch index to load
//   load_bit         bit index to load
//   clear            synchronous drop-to-unsynced
//   synced           high while in the SYNCED state
//   epoch_count      current epoch index within the bit
//   bit_count        current bit index within the subframe
//   bit_strobe       one-cycle pulse at a bit boundary (synced only)
//   subframe_strobe  one-cycle pulse at a subframe boundary (synced only)
//   timeout          one-cycle pulse when the watchdog drops sync
//   load_err         one-cycle pulse when a load request is rejected
// ---------------------------------------------------------------------------
module epoch_counter #(
    parameter int EPOCHS_PER_BIT    = 20,
    parameter int BITS_PER_SUBFRAME = 300,
    parameter int EPOCH_W           = 5,
    parameter int BIT_W             = 9,
    parameter int TIMEOUT_CYCLES    = 32768,
    parameter int WD_W              = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               epoch_in,
    input  logic               load,
    input  logic [EPOCH_W-1:0] load_epoch,
    input  logic [BIT_W-1:0]   load_bit,
    input  logic               clear,
    output logic               synced,
    output logic [EPOCH_W-1:0] epoch_count,
    output logic [BIT_W-1:0]   bit_count,
    output logic               bit_strobe,
    output logic               subframe_strobe,
    output logic               timeout,
    output logic               load_err
);

    typedef enum logic {
        UNSYNCED = 1'b0,
        SYNCED   = 1'b1
    } state_t;

    localparam logic [EPOCH_W-1:0] EPOCH_LAST = EPOCH_W'(EPOCHS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(BITS_PER_SUBFRAME - 1);
    localparam logic [WD_W-1:0]    WD_MAX     = WD_W'(TIMEOUT_CYCLES);

    state_t             state;
    state_t             state_next;
    logic [EPOCH_W-1:0] epoch_next;
    logic [BIT_W-1:0]   bit_next;
    logic [WD_W-1:0]    wd;
    logic [WD_W-1:0]    wd_next;
    logic               bit_strobe_next;
    logic               subframe_strobe_next;
    logic               timeout_next;
    logic               load_err_next;
    logic               load_ok;
    logic               epoch_wrap;
    logic               bit_wrap;

    assign load_ok    = (load_epoch <= EPOCH_LAST) && (load_bit <= BIT_LAST);
    assign epoch_wrap = (epoch_count == EPOCH_LAST);
    assign bit_wrap   = (bit_count == BIT_LAST);
    assign synced     = (state == SYNCED);

    // Next-state logic. Priority is clear, then load, then epoch_in. A load
    // request (accepted or rejected) consumes the epoch strobe of its cycle.
    // Any path that restarts the watchdog sets wd_next to zero, so the
    // timeout test at the end can only fire on a genuinely idle cycle.
    always_comb begin
        state_next           = state;
        epoch_next           = epoch_count;
        bit_next             = bit_count;
        wd_next              = (wd == WD_MAX) ? wd : wd + WD_W'(1);
        bit_strobe_next      = 1'b0;
        subframe_strobe_next = 1'b0;
        timeout_next         = 1'b0;
        load_err_next        = 1'b0;

        if (clear) begin
            state_next = UNSYNCED;
            epoch_next = '0;
            bit_next   = '0;
            wd_next    = '0;
        end else if (load) begin
            if (load_ok) begin
                state_next = SYNCED;
                epoch_next = load_epoch;
                bit_next   = load_bit;
                wd_next    = '0;
            end else begin
                load_err_next = 1'b1;
            end
        end else if (epoch_in) begin
            wd_next = '0;
            if (epoch_wrap) begin
                epoch_next = '0;
                bit_next   = bit_wrap ? '0 : bit_count + BIT_W'(1);
                if (state == SYNCED) begin
                    bit_strobe_next      = 1'b1;
                    subframe_strobe_next = bit_wrap;
                end
            end else begin
                epoch_next = epoch_count + EPOCH_W'(1);
            end
        end

        // The watchdog only drops sync on the cycle it first saturates; once
        // unsynced it stays parked at the limit without further pulses.
        if ((state == SYNCED) && (wd != WD_MAX) && (wd_next == WD_MAX)) begin
            state_next   = UNSYNCED;
            timeout_next = 1'b1;
        end
    end

    // State, counters, watchdog and the registered pulse outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= UNSYNCED;
            epoch_count     <= '0;
            bit_count       <= '0;
            wd              <= '0;
            bit_strobe      <= 1'b0;
            subframe_strobe <= 1'b0;
            timeout         <= 1'b0;
            load_err        <= 1'b0;
        end else begin
            state           <= state_next;
            epoch_count     <= epoch_next;
            bit_count       <= bit_next;
            wd              <= wd_next;
            bit_strobe      <= bit_strobe_next;
            subframe_strobe <= subframe_strobe_next;
            timeout         <= timeout_next;
            load_err        <= load_err_next;
        end
    end

endmodule

// File: tb/tb_epoch_counter.sv
// ---------------------------------------------------------------------------
// tb_epoch_counter
//
// Self-checking bench for epoch_counter. The reference model tracks the
// position inside a subframe as one absolute epoch number (bit*20 + epoch,
// modulo 6000) plus a count of idle cycles, and derives the expected counters
// and pulses from that. Directed scenarios are followed by a random phase.
// ---------------------------------------------------------------------------
module tb_epoch_counter;

    localparam int EPB     = 20;
    localparam int BPS     = 300;
    localparam int TMO     = 32768;
    localparam int EPOCH_W = 5;
    localparam int BIT_W   = 9;

    logic               clk = 1'b0;
    logic               reset;
    logic               epoch_in;
    logic               load;
    logic [EPOCH_W-1:0] load_epoch;
    logic [BIT_W-1:0]   load_bit;
    logic               clear;
    logic               synced;
    logic [EPOCH_W-1:0] epoch_count;
    logic [BIT_W-1:0]   bit_count;
    logic               bit_strobe;
    logic               subframe_strobe;
    logic               timeout;
    logic               load_err;

    int tests_run = 0;
    int failures  = 0;

    // Reference model state
    bit m_synced;
    int m_pos;
    int m_idle;
    bit m_bs;
    bit m_sfs;
    bit m_to;
    bit m_le;

    // Observed pulse tallies, cleared by each scenario that needs them
    int bs_seen;
    int sfs_seen;
    int to_seen;
    int le_seen;

    always #5 clk = ~clk;

    epoch_counter dut (
        .clk             (clk),
        .reset           (reset),
        .epoch_in        (epoch_in),
        .load            (load),
        .load_epoch      (load_epoch),
        .load_bit        (load_bit),
        .clear           (clear),
        .synced          (synced),
        .epoch_count     (epoch_count),
        .bit_count       (bit_count),
        .bit_strobe      (bit_strobe),
        .subframe_strobe (subframe_strobe),
        .timeout         (timeout),
        .load_err        (load_err)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_synced = 1'b0;
        m_pos    = 0;
        m_idle   = 0;
        m_bs     = 1'b0;
        m_sfs    = 1'b0;
        m_to     = 1'b0;
        m_le     = 1'b0;
    endtask

    // One clock edge of the reference model, from the inputs seen at that edge.
    task automatic modelStep(input bit ep, input bit ld, input int le,
                             input int lb, input bit clr);
        m_bs  = 1'b0;
        m_sfs = 1'b0;
        m_to  = 1'b0;
        m_le  = 1'b0;
        if (clr) begin
            m_synced = 1'b0;
            m_pos    = 0;
            m_idle   = 0;
        end else if (ld && le < EPB && lb < BPS) begin
            m_synced = 1'b1;
            m_pos    = lb * EPB + le;
            m_idle   = 0;
        end else if (ep && !ld) begin
            m_pos  = (m_pos + 1) % (EPB * BPS);
            m_idle = 0;
            if (m_synced && (m_pos % EPB) == 0) m_bs = 1'b1;
            if (m_synced && m_pos == 0) m_sfs = 1'b1;
        end else begin
            if (ld) m_le = 1'b1;
            if (m_idle < TMO) begin
                m_idle++;
                if (m_idle == TMO && m_synced) begin
                    m_synced = 1'b0;
                    m_to     = 1'b1;
                end
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("synced", synced, m_synced);
        checkOutput("epoch_count", epoch_count, m_pos % EPB);
        checkOutput("bit_count", bit_count, m_pos / EPB);
        checkOutput("bit_strobe", bit_strobe, m_bs);
        checkOutput("subframe_strobe", subframe_strobe, m_sfs);
        checkOutput("timeout", timeout, m_to);
        checkOutput("load_err", load_err, m_le);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then check
    // all outputs 1 ns after the edge.
    task automatic applyStimulus(input bit ep, input bit ld, input int le,
                                 input int lb, input bit clr);
        epoch_in   = ep;
        load       = ld;
        load_epoch = EPOCH_W'(le);
        load_bit   = BIT_W'(lb);
        clear      = clr;
        @(posedge clk);
        if (reset) modelStep(ep, ld, le, lb, clr);
        else       modelReset();
        #1;
        checkAll();
        if (bit_strobe)      bs_seen++;
        if (subframe_strobe) sfs_seen++;
        if (timeout)         to_seen++;
        if (load_err)        le_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
    endtask

    task automatic clearSeen();
        bs_seen  = 0;
        sfs_seen = 0;
        to_seen  = 0;
        le_seen  = 0;
    endtask

    initial begin
        reset      = 1'b0;
        epoch_in   = 1'b0;
        load       = 1'b0;
        load_epoch = '0;
        load_bit   = '0;
        clear      = 1'b0;
        modelReset();
        clearSeen();

        // Reset state
        idle(2);
        reset = 1'b1;
        idle(2);

        // 40 epochs unsynced: counters free-run, no strobes
        clearSeen();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            applyStimulus(0, 0, 0, 0, 0);
        end
        checkOutput("t1_epoch", epoch_count, 0);
        checkOutput("t1_bit", bit_count, 2);
        checkOutput("t1_synced", synced, 0);
        checkOutput("t1_bs_seen", bs_seen, 0);
        checkOutput("t1_sfs_seen", sfs_seen, 0);

        // Load 18/299 then two epochs: subframe boundary
        applyStimulus(0, 1, 18, 299, 0);
        checkOutput("t2_synced", synced, 1);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t2_epoch", epoch_count, 0);
        checkOutput("t2_bit", bit_count, 0);
        checkOutput("t2_bs", bit_strobe, 1);
        checkOutput("t2_sfs", subframe_strobe, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t2_bs_end", bit_strobe, 0);
        checkOutput("t2_sfs_end", subframe_strobe, 0);

        // Invalid load: rejected, pulse one cycle
        applyStimulus(0, 1, 20, 5, 0);
        checkOutput("t3_load_err", load_err, 1);
        checkOutput("t3_epoch", epoch_count, 0);
        checkOutput("t3_bit", bit_count, 0);
        checkOutput("t3_synced", synced, 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("t3_load_err_end", load_err, 0);

        // Load beats a coincident epoch
        applyStimulus(1, 1, 5, 10, 0);
        checkOutput("t4_epoch", epoch_count, 5);
        checkOutput("t4_bit", bit_count, 10);
        idle(1);
        checkOutput("t4_epoch_hold", epoch_count, 5);

        // Clear beats a coincident load
        clearSeen();
        applyStimulus(0, 1, 7, 7, 1);
        checkOutput("t4_clr_synced", synced, 0);
        checkOutput("t4_clr_epoch", epoch_count, 0);
        checkOutput("t4_clr_bit", bit_count, 0);
        idle(1);
        checkOutput("t4_clr_le_seen", le_seen, 0);

        // Watchdog timeout in SYNCED, then no repeat, then recovery by load
        applyStimulus(0, 1, 3, 100, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            applyStimulus(0, 0, 0, 0, 0);
        end
        clearSeen();
        idle(TMO + 100);
        checkOutput("t5_to_seen", to_seen, 1);
        checkOutput("t5_synced", synced, 0);
        checkOutput("t5_epoch_held", epoch_count, 6);
        checkOutput("t5_bit_held", bit_count, 100);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("t5_resync", synced, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bit ep, ld, clr;
            int le, lb;
            ep  = ($urandom_range(0, 99) < 40);
            ld  = ($urandom_range(0, 99) < 3);
            clr = ($urandom_range(0, 199) == 0);
            le  = $urandom_range(0, 23);
            lb  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 299)
                                              : $urandom_range(290, 305);
            applyStimulus(ep, ld, le, lb, clr);
        end

        // Asynchronous reset at epoch 19 as an epoch arrives
        applyStimulus(0, 1, 19, 5, 0);
        epoch_in = 1'b1;
        reset    = 1'b0;
        #1;
        modelReset();
        checkAll();
        checkOutput("t6_synced", synced, 0);
        checkOutput("t6_epoch", epoch_count, 0);
        applyStimulus(1, 0, 0, 0, 0);
        idle(2);
        reset = 1'b1;
        clearSeen();
        for (int i = 0; i < 25; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            applyStimulus(0, 0, 0, 0, 0);
        end
        checkOutput("t6_bs_seen", bs_seen, 0);
        checkOutput("t6_sfs_seen", sfs_seen, 0);
        checkOutput("t6_epoch_after", epoch_count, 5);
        checkOutput("t6_bit_after", bit_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/epoch_counter.md
Name: epoch_counter

Overview:
- Consumes the single-cycle code-epoch strobe (1 ms C/A code rollover, produced by the edge-strobe stage) and divides it into navigation-bit and subframe boundaries.
- Keeps epoch-within-bit and bit-within-subframe counters, aligned by a load from bit-sync logic.
- Emits bit and subframe strobes to the data demodulator only while synced.
- A watchdog drops sync if the epoch strobe stops.

Parameters:
- EPOCHS_PER_BIT, 20, code epochs per navigation bit.
- BITS_PER_SUBFRAME, 300, bits per subframe.
- EPOCH_W, 5, width of epoch counter; must hold EPOCHS_PER_BIT-1.
- BIT_W, 9, width of bit counter; must hold BITS_PER_SUBFRAME-1.
- TIMEOUT_CYCLES, 32768, clk cycles without epoch_in before sync is dropped.
- WD_W, 16, watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- epoch_in  in  1  single-cycle code-epoch strobe.
- load  in  1  single-cycle alignment request.
- load_epoch  in  EPOCH_W  epoch index to load.
- load_bit  in  BIT_W  bit index to load.
- clear  in  1  synchronous drop-to-unsynced.
- synced  out  1  high in SYNCED state.
- epoch_count  out  EPOCH_W  current epoch index within bit.
- bit_count  out  BIT_W  current bit index within subframe.
- bit_strobe  out  1  one-cycle pulse at bit boundary.
- subframe_strobe  out  1  one-cycle pulse at subframe boundary.
- timeout  out  1  one-cycle pulse when watchdog drops sync.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (reset=0, async): state UNSYNCED; epoch_count=0, bit_count=0, watchdog=0; every output 0. Reset mid-count discards all state with no strobes.
- States: UNSYNCED, SYNCED. synced = (state==SYNCED), registered.
- Counting, in both states:
  - On epoch_in, epoch_count increments.
  - At EPOCHS_PER_BIT-1 it wraps to 0 and bit_count increments.
  - bit_count wraps from BITS_PER_SUBFRAME-1 to 0.
  - All arithmetic is modulo the parameter, never modulo 2^width.
- Strobes are registered: asserted the cycle after the epoch_in that causes the wrap, for exactly one cycle.
  - bit_strobe fires on an epoch wrap, SYNCED only.
  - subframe_strobe fires on an epoch wrap and bit wrap together, SYNCED only, coincident with bit_strobe.
  - In UNSYNCED the counters free-run and the strobes stay 0.
- Load:
  - Valid load (load_epoch<EPOCHS_PER_BIT and load_bit<BITS_PER_SUBFRAME): counters take the load values at the next edge, state goes to SYNCED, watchdog goes to 0. No strobe is generated by the load itself.
  - Invalid load: counters and state unchanged; load_err pulses one cycle later.
- Priority within one cycle: clear > load > epoch_in.
  - load with epoch_in: load wins and that epoch is not counted.
  - clear with load: clear wins; load ignored, no load_err.
- Clear: state goes to UNSYNCED; epoch_count and bit_count go to 0; watchdog goes to 0.
- Watchdog:
  - Counts clk cycles since the last epoch_in and resets to 0 on epoch_in or load.
  - It saturates at TIMEOUT_CYCLES.
  - In SYNCED, when it reaches TIMEOUT_CYCLES: state goes to UNSYNCED and timeout pulses one cycle. Counters are held, not zeroed.
  - In UNSYNCED it saturates silently with no timeout.
- Latency: epoch_in to counter update is 1 cycle; epoch_in to strobe is 1 cycle, the same edge as the counter wrap.
- epoch_in asserted on consecutive cycles counts once per cycle high. The upstream strobe guarantees single-cycle pulses.

Test Plan:
- Reset release, 40 epoch_in pulses, no load -> counters reach epoch 0, bit 2; bit_strobe and subframe_strobe never assert; synced=0.
- load epoch=18, bit=299, then 2 epoch_in -> synced=1; the second epoch leaves epoch=0, bit=0; bit_strobe and subframe_strobe both high for exactly 1 cycle after it.
- load epoch=20 (invalid) -> load_err pulse 1 cycle later; counters and synced unchanged.
- In SYNCED, epoch_in and load(epoch=5, bit=10) in the same cycle -> counters read 5/10 and the epoch is not counted. Separately, clear with load in the same cycle -> synced=0, counters 0/0, no load_err.
- In SYNCED, stop epoch_in for 32768 cycles -> timeout pulses once, synced=0, counters held. Further idle gives no repeat pulse. The next valid load restores synced.
- Assert reset mid-stream at epoch 19 as epoch_in arrives -> all outputs 0 immediately; no strobe after release.
